// File: rtl/usart_rx_frame_assembler.sv
// USART receive frame assembler: walks start, data, optional parity and stop
// bits on bit-centre ticks and delivers a registered parallel frame with status.
module usart_rx_frame_assembler (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_rx_en,
    input  logic       i_bit_tick,
    input  logic       i_rxd,
    input  logic [2:0] i_frame_size,
    input  logic       i_parity_on,
    input  logic       i_two_stop,
    output logic [8:0] o_frame,
    output logic       o_parity_bit,
    output logic       o_parity_en,
    output logic       o_frame_valid,
    output logic       o_frame_error,
    output logic       o_busy
);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_DATA   = 3'd1;
    localparam logic [2:0] ST_PARITY = 3'd2;
    localparam logic [2:0] ST_STOP1  = 3'd3;
    localparam logic [2:0] ST_STOP2  = 3'd4;

    // Reserved codes 100/101/110 fall back to an 8-bit frame.
    function automatic logic [3:0] size_to_bits(input logic [2:0] code);
        case (code)
            3'b000:  size_to_bits = 4'd5;
            3'b001:  size_to_bits = 4'd6;
            3'b010:  size_to_bits = 4'd7;
            3'b111:  size_to_bits = 4'd9;
            default: size_to_bits = 4'd8;
        endcase
    endfunction

    logic [2:0] state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [3:0] nbits_q, nbits_d;
    logic [8:0] shift_q, shift_d;
    logic       par_on_q, par_on_d;
    logic       two_stop_q, two_stop_d;
    logic       par_bit_q, par_bit_d;
    logic       err1_q, err1_d;
    logic [8:0] frame_q, frame_d;
    logic       parity_bit_q, parity_bit_d;
    logic       parity_en_q, parity_en_d;
    logic       valid_q, valid_d;
    logic       error_q, error_d;
    logic       busy_q, busy_d;
    logic       done_s;
    logic       stop_err_s;

    // Next-state and frame-completion logic.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        nbits_d      = nbits_q;
        shift_d      = shift_q;
        par_on_d     = par_on_q;
        two_stop_d   = two_stop_q;
        par_bit_d    = par_bit_q;
        err1_d       = err1_q;
        frame_d      = frame_q;
        parity_bit_d = parity_bit_q;
        error_d      = error_q;
        parity_en_d  = 1'b0;
        valid_d      = 1'b0;
        done_s       = 1'b0;
        stop_err_s   = 1'b0;
        if (!i_rx_en) begin
            state_d = ST_IDLE;
        end else if (i_bit_tick) begin
            case (state_q)
                ST_IDLE: begin
                    if (!i_rxd) begin
                        state_d    = ST_DATA;
                        nbits_d    = size_to_bits(i_frame_size);
                        par_on_d   = i_parity_on;
                        two_stop_d = i_two_stop;
                        shift_d    = 9'd0;
                        cnt_d      = 4'd0;
                        par_bit_d  = 1'b0;
                        err1_d     = 1'b0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_DATA: begin
                    shift_d[cnt_q] = i_rxd;
                    cnt_d          = cnt_q + 4'd1;
                    if (cnt_q == nbits_q - 4'd1) begin
                        state_d = par_on_q ? ST_PARITY : ST_STOP1;
                    end else begin
                        state_d = ST_DATA;
                    end
                end
                ST_PARITY: begin
                    par_bit_d = i_rxd;
                    state_d   = ST_STOP1;
                end
                ST_STOP1: begin
                    err1_d = ~i_rxd;
                    if (two_stop_q) begin
                        state_d = ST_STOP2;
                    end else begin
                        state_d    = ST_IDLE;
                        done_s     = 1'b1;
                        stop_err_s = ~i_rxd;
                    end
                end
                ST_STOP2: begin
                    state_d    = ST_IDLE;
                    done_s     = 1'b1;
                    stop_err_s = err1_q | ~i_rxd;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end else begin
            state_d = state_q;
        end
        // Completion registers the frame on the same edge as the final stop tick.
        if (done_s) begin
            frame_d      = shift_q;
            parity_bit_d = par_on_q ? par_bit_q : 1'b0;
            error_d      = stop_err_s;
            valid_d      = 1'b1;
            parity_en_d  = par_on_q;
        end else begin
            valid_d = 1'b0;
        end
        busy_d = (state_d != ST_IDLE);
    end

    // State and registered outputs.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q      <= ST_IDLE;
            cnt_q        <= 4'd0;
            nbits_q      <= 4'd0;
            shift_q      <= 9'd0;
            par_on_q     <= 1'b0;
            two_stop_q   <= 1'b0;
            par_bit_q    <= 1'b0;
            err1_q       <= 1'b0;
            frame_q      <= 9'd0;
            parity_bit_q <= 1'b0;
            parity_en_q  <= 1'b0;
            valid_q      <= 1'b0;
            error_q      <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            nbits_q      <= nbits_d;
            shift_q      <= shift_d;
            par_on_q     <= par_on_d;
            two_stop_q   <= two_stop_d;
            par_bit_q    <= par_bit_d;
            err1_q       <= err1_d;
            frame_q      <= frame_d;
            parity_bit_q <= parity_bit_d;
            parity_en_q  <= parity_en_d;
            valid_q      <= valid_d;
            error_q      <= error_d;
            busy_q       <= busy_d;
        end
    end

    assign o_frame       = frame_q;
    assign o_parity_bit  = parity_bit_q;
    assign o_parity_en   = parity_en_q;
    assign o_frame_valid = valid_q;
    assign o_frame_error = error_q;
    assign o_busy        = busy_q;

endmodule

// File: doc/usart_rx_frame_assembler.md
# usart_rx_frame_assembler

Receive-side frame assembler for the USART. It consumes the synchronized serial line and the bit-centre sample strobe from the clock-recovery stage, and walks start, data, optional parity and stop bits. It delivers a parallel data frame, the received parity bit and a parity-enable strobe to the downstream parity checker, plus frame-valid and frame-error flags to the receive buffer.

## Interface
Parameters: none. Data width is fixed at 9 bits.

Ports:
- i_clk  input  1  system clock; all flops on rising edge
- i_rst_n  input  1  asynchronous, active-low reset
- i_rx_en  input  1  receiver enable (RXEN); low aborts any frame and holds IDLE
- i_bit_tick  input  1  one-cycle strobe at each bit centre; the only sampling instant
- i_rxd  input  1  synchronized, majority-voted RX line level
- i_frame_size  input  3  data length code: 000=5, 001=6, 010=7, 011=8, 111=9 bits; 100/101/110 are treated as 8
- i_parity_on  input  1  parity bit present in frame (UPM1)
- i_two_stop  input  1  two stop bits (USBS)
- o_frame  output  9  received data, LSB first on line, zero-extended above frame size
- o_parity_bit  output  1  received parity bit; 0 when parity is off
- o_parity_en  output  1  one-cycle strobe, = o_frame_valid & latched parity_on; write enable for the parity checker result
- o_frame_valid  output  1  one-cycle strobe: frame complete
- o_frame_error  output  1  stop-bit error for the frame flagged by o_frame_valid; held until next valid
- o_busy  output  1  high in any state except IDLE

## Operation
- FSM states: IDLE, DATA, PARITY, STOP1, STOP2.
- IDLE:
  - tick with rxd=0 → DATA. The start bit is confirmed at its centre.
  - On this transition: latch i_frame_size, i_parity_on and i_two_stop; clear the shift register and bit counter.
  - tick with rxd=1 → stay in IDLE.
- DATA:
  - Each tick writes rxd into shift[cnt], then cnt++.
  - On the tick where cnt == N-1, go to PARITY if parity is latched on, else STOP1.
  - Bits at index ≥ N stay 0.
- PARITY: tick captures rxd as the parity bit → STOP1.
- STOP1:
  - tick records err1 = ~rxd.
  - Then → STOP2 if two_stop is latched on.
  - Otherwise the frame completes → IDLE.
- STOP2: tick records err2 = ~rxd; the frame completes → IDLE.
- Frame completion, on the same edge as the final tick:
  - register o_frame ← shift and o_parity_bit ← captured parity;
  - o_frame_error ← err1 | err2;
  - pulse o_frame_valid, and o_parity_en if parity is on.
- A stop error does not suppress the frame. It is delivered with the error flag set, and the FSM returns to IDLE without waiting for the line to go high. A low line at the next tick is then taken as a new start bit.
- Config inputs changing mid-frame have no effect until the next start.
- i_rx_en low:
  - FSM → IDLE on the next edge; the partial frame is discarded and no valid is issued.
  - o_frame, o_parity_bit and o_frame_error keep their last values.
- Ticks while i_rx_en is low are ignored.

## Timing
- Reset values: all outputs 0, FSM IDLE, counter 0, shift register 0.
- Outputs are registered. o_frame_valid and o_parity_en are high for exactly the cycle after the edge that sampled the final stop bit.
- o_frame, o_parity_bit and o_frame_error update on that same edge and stay stable until the next valid.
- Ticks counted from start-bit tick to valid: 1 + N + P + S, where P∈{0,1} and S∈{1,2}.
- No action occurs without i_bit_tick. Back-to-back ticks on consecutive cycles must be handled.
- Reset asserted mid-frame returns everything to reset values asynchronously. The frame in progress is lost.

## Test plan
- 8N1, line bits 0,(1,0,1,0,0,1,0,1),1 on ticks → o_frame=9'h0A5, o_frame_valid and o_frame_error=0 one cycle after the 10th tick; o_parity_en stays 0.
- 5-bit even parity, 1 stop; data 10110 sent LSB first as 0,1,1,0,1; parity bit 1; stop 1 → o_frame=9'h016, o_parity_bit=1, o_parity_en pulse coincident with valid.
- 9-bit, 2 stop, second stop bit 0 → o_frame=9'h1FF for all-ones data, o_frame_error=1, valid after 12 ticks; the next frame with good stops clears the error.
- Reserved size code 101 with 8 data bits 8'h3C → treated as 8 bits, o_frame=9'h03C.
- i_rx_en dropped after the 4th data tick → o_busy falls the next cycle, no valid, o_frame unchanged. A fresh frame after re-enable is received correctly.
- Async reset pulsed mid-DATA, then a full 7E1 frame → all outputs 0 during reset; the subsequent frame decodes correctly with parity bit captured.
